// File: rtl/cmac_rx_frame_filter.sv
// Store-and-forward RX frame filter: buffers each frame, commits it on a clean tlast,
// and discards bad, oversize, non-fitting and post-reset partial frames whole.
module cmac_rx_frame_filter #(
    parameter int unsigned FIFO_DEPTH      = 512,
    parameter int unsigned MAX_FRAME_BEATS = 150
) (
    input  logic         rx_clk,
    input  logic         resetn,
    input  logic [511:0] rx_in_tdata,
    input  logic [63:0]  rx_in_tkeep,
    input  logic         rx_in_tlast,
    input  logic         rx_in_tuser,
    input  logic         rx_in_tvalid,
    output logic [511:0] rx_out_tdata,
    output logic [63:0]  rx_out_tkeep,
    output logic         rx_out_tlast,
    output logic         rx_out_tvalid,
    input  logic         rx_out_tready,
    output logic [31:0]  good_frames,
    output logic [31:0]  bad_frames,
    output logic [31:0]  ovfl_frames,
    output logic [31:0]  long_frames
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned PW = AW + 1;
    localparam int unsigned LW = $clog2(MAX_FRAME_BEATS + 2);
    localparam int unsigned DW = 512 + 64 + 1;

    localparam logic [1:0] ST_SYNC  = 2'd0;
    localparam logic [1:0] ST_IDLE  = 2'd1;
    localparam logic [1:0] ST_STORE = 2'd2;
    localparam logic [1:0] ST_DROP  = 2'd3;

    logic [1:0]    state_q, state_d;
    logic [PW-1:0] wr_q, wr_d, cmt_q, cmt_d, rd_q;
    logic [LW-1:0] len_q, len_d;
    logic          ovfl_q, ovfl_d;
    logic [31:0]   good_q, good_d, bad_q, bad_d, ovf_q, ovf_d, long_q, long_d;
    logic          we_c, ren_c, out_load_c, admit_c;
    logic [PW-1:0] used_c, free_c;

    logic [DW-1:0] mem [FIFO_DEPTH];
    logic [DW-1:0] ram_q, out_q;
    logic          r_v_q, out_valid_q;

    assign used_c  = cmt_q - rd_q;
    assign free_c  = PW'(FIFO_DEPTH) - (wr_q - rd_q);
    assign admit_c = free_c >= PW'(MAX_FRAME_BEATS);

    // Frame admission, length policing, commit and rollback.
    always_comb begin
        state_d = state_q;
        wr_d    = wr_q;
        cmt_d   = cmt_q;
        len_d   = len_q;
        ovfl_d  = ovfl_q;
        good_d  = good_q;
        bad_d   = bad_q;
        ovf_d   = ovf_q;
        long_d  = long_q;
        we_c    = 1'b0;
        case (state_q)
            ST_SYNC: begin
                if (rx_in_tvalid && rx_in_tlast) state_d = ST_IDLE;
            end
            ST_IDLE: begin
                if (rx_in_tvalid) begin
                    if (admit_c) begin
                        we_c  = 1'b1;
                        wr_d  = wr_q + PW'(1);
                        len_d = LW'(1);
                        if (!rx_in_tlast) begin
                            state_d = ST_STORE;
                        end else if (rx_in_tuser) begin
                            wr_d  = cmt_q;
                            bad_d = bad_q + 32'd1;
                        end else begin
                            cmt_d  = wr_q + PW'(1);
                            good_d = good_q + 32'd1;
                        end
                    end else if (rx_in_tlast) begin
                        ovf_d = ovf_q + 32'd1;
                    end else begin
                        state_d = ST_DROP;
                        ovfl_d  = 1'b1;
                    end
                end
            end
            ST_STORE: begin
                if (rx_in_tvalid) begin
                    if (len_q == LW'(MAX_FRAME_BEATS)) begin
                        wr_d    = cmt_q;
                        long_d  = long_q + 32'd1;
                        ovfl_d  = 1'b0;
                        state_d = rx_in_tlast ? ST_IDLE : ST_DROP;
                    end else begin
                        we_c  = 1'b1;
                        wr_d  = wr_q + PW'(1);
                        len_d = LW'(len_q + LW'(1));
                        if (rx_in_tlast) begin
                            state_d = ST_IDLE;
                            if (rx_in_tuser) begin
                                wr_d  = cmt_q;
                                bad_d = bad_q + 32'd1;
                            end else begin
                                cmt_d  = wr_q + PW'(1);
                                good_d = good_q + 32'd1;
                            end
                        end
                    end
                end
            end
            default: begin
                if (rx_in_tvalid && rx_in_tlast) begin
                    if (ovfl_q) ovf_d = ovf_q + 32'd1;
                    ovfl_d  = 1'b0;
                    state_d = ST_IDLE;
                end
            end
        endcase
    end

    // Read prefetch: ram_q holds one beat ahead of the output register.
    assign out_load_c = r_v_q && (!out_valid_q || rx_out_tready);
    assign ren_c      = (used_c != '0) && (!r_v_q || out_load_c);

    always_ff @(posedge rx_clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= ST_SYNC;
            wr_q        <= '0;
            cmt_q       <= '0;
            rd_q        <= '0;
            len_q       <= '0;
            ovfl_q      <= 1'b0;
            good_q      <= '0;
            bad_q       <= '0;
            ovf_q       <= '0;
            long_q      <= '0;
            r_v_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_q       <= '0;
        end else begin
            state_q <= state_d;
            wr_q    <= wr_d;
            cmt_q   <= cmt_d;
            rd_q    <= rd_q + PW'(ren_c);
            len_q   <= len_d;
            ovfl_q  <= ovfl_d;
            good_q  <= good_d;
            bad_q   <= bad_d;
            ovf_q   <= ovf_d;
            long_q  <= long_d;
            if (ren_c)           r_v_q <= 1'b1;
            else if (out_load_c) r_v_q <= 1'b0;
            if (out_load_c) begin
                out_valid_q <= 1'b1;
                out_q       <= ram_q;
            end else if (rx_out_tready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    // Frame buffer storage; write and read addresses never collide.
    always_ff @(posedge rx_clk) begin
        if (we_c)  mem[wr_q[AW-1:0]] <= {rx_in_tlast, rx_in_tkeep, rx_in_tdata};
        if (ren_c) ram_q <= mem[rd_q[AW-1:0]];
    end

    assign rx_out_tdata  = out_q[511:0];
    assign rx_out_tkeep  = out_q[575:512];
    assign rx_out_tlast  = out_q[576];
    assign rx_out_tvalid = out_valid_q;
    assign good_frames   = good_q;
    assign bad_frames    = bad_q;
    assign ovfl_frames   = ovf_q;
    assign long_frames   = long_q;

endmodule

// File: tb/tb_cmac_rx_frame_filter.sv
// Self-checking bench for cmac_rx_frame_filter: frame table, hand sequences and
// randomized traffic compared against a queue of expected good-frame beats.
module tb_cmac_rx_frame_filter;

    localparam int DEPTH = 512;
    localparam int MAXB  = 150;

    typedef struct packed {
        logic [511:0] d;
        logic [63:0]  k;
        logic         l;
    } beat_t;

    typedef struct {
        int beats;
        bit user;
        int good;
        int bad;
        int lng;
    } vec_t;

    logic         rx_clk, resetn;
    logic [511:0] rx_in_tdata;
    logic [63:0]  rx_in_tkeep;
    logic         rx_in_tlast, rx_in_tuser, rx_in_tvalid;
    logic [511:0] rx_out_tdata;
    logic [63:0]  rx_out_tkeep;
    logic         rx_out_tlast, rx_out_tvalid, rx_out_tready;
    logic [31:0]  good_frames, bad_frames, ovfl_frames, long_frames;

    cmac_rx_frame_filter #(.FIFO_DEPTH(DEPTH), .MAX_FRAME_BEATS(MAXB)) dut (
        .rx_clk(rx_clk), .resetn(resetn),
        .rx_in_tdata(rx_in_tdata), .rx_in_tkeep(rx_in_tkeep), .rx_in_tlast(rx_in_tlast),
        .rx_in_tuser(rx_in_tuser), .rx_in_tvalid(rx_in_tvalid),
        .rx_out_tdata(rx_out_tdata), .rx_out_tkeep(rx_out_tkeep), .rx_out_tlast(rx_out_tlast),
        .rx_out_tvalid(rx_out_tvalid), .rx_out_tready(rx_out_tready),
        .good_frames(good_frames), .bad_frames(bad_frames),
        .ovfl_frames(ovfl_frames), .long_frames(long_frames)
    );

    initial rx_clk = 1'b0;
    always #5 rx_clk = ~rx_clk;

    beat_t exp_q[$];
    vec_t  vecs[8];
    int    errs, checks, out_cnt, rdy_mode;
    bit    mon_en;
    int    exp_good, exp_bad, exp_long, exp_ovfl;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge rx_clk);
        #1;
    endtask

    task automatic idle(input int n);
        rx_in_tvalid = 1'b0;
        repeat (n) step();
    endtask

    task automatic drive_beat(input beat_t b, input bit user);
        rx_in_tdata  = b.d;
        rx_in_tkeep  = b.k;
        rx_in_tlast  = b.l;
        rx_in_tuser  = b.l ? user : 1'($urandom());
        rx_in_tvalid = 1'b1;
    endtask

    task automatic send_frame(input int n, input bit user, input bit pass, input int gap_pct);
        for (int i = 0; i < n; i++) begin
            beat_t b;
            for (int w = 0; w < 16; w++) b.d[w*32 +: 32] = $urandom();
            b.k = {$urandom(), $urandom()};
            b.l = (i == n - 1);
            if (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) begin
                rx_in_tvalid = 1'b0;
                step();
            end
            drive_beat(b, user);
            if (pass) exp_q.push_back(b);
            step();
        end
        rx_in_tvalid = 1'b0;
        rx_in_tlast  = 1'b0;
        rx_in_tuser  = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        int t;
        t = 0;
        while ((exp_q.size() != 0 || rx_out_tvalid) && t < budget) begin
            step();
            t++;
        end
        check32("drain_timeout", 32'(t < budget), 32'd1);
    endtask

    task automatic check_counters(input string tag);
        check32({tag, "_good"}, good_frames, 32'(exp_good));
        check32({tag, "_bad"},  bad_frames,  32'(exp_bad));
        check32({tag, "_long"}, long_frames, 32'(exp_long));
        check32({tag, "_ovfl"}, ovfl_frames, 32'(exp_ovfl));
    endtask

    initial begin
        logic [511:0] pd;
        logic [63:0]  pk;
        logic         pl, prev_stall;
        beat_t        e;
        int           base, t;
        bit           user;
        int           n;

        errs = 0; checks = 0; out_cnt = 0; rdy_mode = 1; mon_en = 1'b1;
        exp_good = 0; exp_bad = 0; exp_long = 0; exp_ovfl = 0;
        resetn = 1'b0; rx_out_tready = 1'b0;
        rx_in_tdata = '0; rx_in_tkeep = '0; rx_in_tlast = 1'b0; rx_in_tuser = 1'b0; rx_in_tvalid = 1'b0;

        vecs[0] = '{5,   1'b1, 1, 1, 0};
        vecs[1] = '{2,   1'b0, 2, 1, 0};
        vecs[2] = '{151, 1'b0, 2, 1, 1};
        vecs[3] = '{1,   1'b0, 3, 1, 1};
        vecs[4] = '{150, 1'b0, 4, 1, 1};
        vecs[5] = '{152, 1'b1, 4, 1, 2};
        vecs[6] = '{1,   1'b1, 4, 2, 2};
        vecs[7] = '{3,   1'b0, 5, 2, 2};

        fork
            forever begin
                @(posedge rx_clk);
                #1;
                case (rdy_mode)
                    0:       rx_out_tready = 1'b0;
                    1:       rx_out_tready = 1'b1;
                    default: rx_out_tready = ($urandom_range(0, 99) < 70);
                endcase
            end
            begin
                prev_stall = 1'b0; pd = '0; pk = '0; pl = 1'b0;
                forever begin
                    @(negedge rx_clk);
                    if (!mon_en || !resetn) begin
                        prev_stall = 1'b0;
                    end else begin
                        if (prev_stall) begin
                            checks++;
                            if (!rx_out_tvalid || rx_out_tdata !== pd || rx_out_tkeep !== pk || rx_out_tlast !== pl) begin
                                errs++;
                                $display("FAIL stall_stable: valid=%0b last=%0b keep=%h expected held keep=%h last=%0b",
                                         rx_out_tvalid, rx_out_tlast, rx_out_tkeep, pk, pl);
                            end
                        end
                        if (rx_out_tvalid && rx_out_tready) begin
                            out_cnt++;
                            checks++;
                            if (exp_q.size() == 0) begin
                                errs++;
                                $display("FAIL unexpected_beat: got beat %0d with last=%0b, expected none", out_cnt, rx_out_tlast);
                            end else begin
                                e = exp_q.pop_front();
                                if ({rx_out_tdata, rx_out_tkeep, rx_out_tlast} !== e) begin
                                    errs++;
                                    $display("FAIL beat_%0d: got d=%h k=%h l=%0b expected d=%h k=%h l=%0b",
                                             out_cnt, rx_out_tdata, rx_out_tkeep, rx_out_tlast, e.d, e.k, e.l);
                                end
                            end
                        end
                        prev_stall = rx_out_tvalid && !rx_out_tready;
                        pd = rx_out_tdata; pk = rx_out_tkeep; pl = rx_out_tlast;
                    end
                end
            end
        join_none

        repeat (3) step();
        check32("rst_tvalid", 32'(rx_out_tvalid), 32'd0);
        check_counters("rst");
        resetn = 1'b1;
        step();

        // Post-reset partial frame is swallowed, next frame passes with 2-cycle latency.
        send_frame(3, 1'b0, 1'b0, 0);
        send_frame(4, 1'b0, 1'b1, 0);
        check32("lat_c0", 32'(rx_out_tvalid), 32'd0);
        step();
        check32("lat_c1", 32'(rx_out_tvalid), 32'd0);
        step();
        check32("lat_c2", 32'(rx_out_tvalid), 32'd1);
        wait_drain(200);
        exp_good = 1;
        check_counters("sync");

        for (int i = 0; i < 8; i++) begin
            send_frame(vecs[i].beats, vecs[i].user, (vecs[i].beats <= MAXB) && !vecs[i].user, 0);
            wait_drain(500);
            idle(2);
            exp_good = vecs[i].good;
            exp_bad  = vecs[i].bad;
            exp_long = vecs[i].lng;
            check_counters($sformatf("vec%0d", i));
        end

        // Output stalled: three full-size frames fit, the fourth is dropped for space.
        rdy_mode = 0;
        idle(2);
        base = out_cnt;
        for (int k = 0; k < 4; k++) send_frame(MAXB, 1'b0, k < 3, 0);
        idle(3);
        exp_good += 3;
        exp_ovfl = 1;
        check_counters("ovfl");
        rdy_mode = 1;
        wait_drain(2000);
        check32("ovfl_delivered", 32'(out_cnt - base), 32'd450);

        // Random traffic with 70% ready duty; throttled so admission never fails.
        rdy_mode = 2;
        for (int f = 0; f < 1000; f++) begin
            t = 0;
            while (exp_q.size() > DEPTH - 2 * MAXB - 4 && t < 5000) begin
                idle(1);
                t++;
            end
            if (t >= 5000) check32("throttle_timeout", 32'd0, 32'd1);
            n = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, MAXB)) : int'($urandom_range(1, 16));
            user = ($urandom_range(0, 3) == 0);
            send_frame(n, user, !user, 10);
            if (user) exp_bad++;
            else      exp_good++;
        end
        wait_drain(20000);
        idle(2);
        check_counters("rand");

        // Reset mid-frame with committed data queued and output stalled.
        rdy_mode = 0;
        idle(2);
        send_frame(3, 1'b0, 1'b1, 0);
        send_frame(2, 1'b0, 1'b1, 0);
        for (int i = 0; i < 4; i++) begin
            beat_t b;
            b.d = '1; b.k = '1; b.l = 1'b0;
            drive_beat(b, 1'b0);
            step();
        end
        mon_en = 1'b0;
        rx_in_tvalid = 1'b0;
        resetn = 1'b0;
        #1;
        exp_good = 0; exp_bad = 0; exp_long = 0; exp_ovfl = 0;
        check32("mrst_tvalid", 32'(rx_out_tvalid), 32'd0);
        check_counters("mrst");
        exp_q.delete();
        step();
        step();
        resetn = 1'b1;
        mon_en = 1'b1;
        rdy_mode = 1;
        step();
        send_frame(5, 1'b0, 1'b0, 0);
        idle(6);
        check32("mrst_sync_tvalid", 32'(rx_out_tvalid), 32'd0);
        check_counters("mrst_sync");
        send_frame(2, 1'b0, 1'b1, 0);
        wait_drain(200);
        exp_good = 1;
        check_counters("mrst_after");

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
